// File: rtl/board_store.sv
// board_store: 16x16 five-in-a-row board memory, placement sequencer and
// check-chain handshake. Optional undo support is enabled by BOARD_STORE_UNDO_EN.
module board_store #(
  parameter logic [1:0] CLEAR_VAL = 2'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] pointer,
  input  logic       place_valid,
`ifdef BOARD_STORE_UNDO_EN
  input  logic       undo_valid,
`endif
  output logic       place_ready,
  output logic       place_ok,
  output logic       place_err,
  output logic [1:0] chess,
  output logic       active,
  input  logic       check_done,
  input  logic [7:0] address,
  output logic [1:0] currstate,
  output logic [1:0] turn,
  output logic [8:0] move_count,
  output logic       board_full
);

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_CHECK = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] clr_cnt_q, clr_cnt_d;
  logic [1:0] cells_q [256];
  logic       place_ok_q, place_ok_d;
  logic       place_err_q, place_err_d;
  logic [1:0] chess_q, chess_d;
  logic       active_q, active_d;
  logic [1:0] turn_q, turn_d;
  logic [8:0] move_count_q, move_count_d;

  logic       cell_we_s;
  logic [7:0] cell_waddr_s;
  logic [1:0] cell_wdata_s;
  logic       full_s;
  logic       ready_s;
  logic [1:0] target_cell_s;

`ifdef BOARD_STORE_UNDO_EN
  logic       hist_valid_q, hist_valid_d;
  logic [7:0] hist_addr_q, hist_addr_d;
  logic [1:0] hist_stone_q, hist_stone_d;
`endif

  assign full_s        = (move_count_q == 9'd256);
  assign ready_s       = (state_q == S_IDLE) && !full_s;
  assign target_cell_s = cells_q[pointer];

  // Next-state and output decode for the clear/idle/check sequencer
  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    place_ok_d   = 1'b0;
    place_err_d  = 1'b0;
    chess_d      = chess_q;
    active_d     = active_q;
    turn_d       = turn_q;
    move_count_d = move_count_q;
    cell_we_s    = 1'b0;
    cell_waddr_s = 8'd0;
    cell_wdata_s = CLEAR_VAL;
`ifdef BOARD_STORE_UNDO_EN
    hist_valid_d = hist_valid_q;
    hist_addr_d  = hist_addr_q;
    hist_stone_d = hist_stone_q;
`endif
    case (state_q)
      S_CLEAR: begin
        cell_we_s    = 1'b1;
        cell_waddr_s = clr_cnt_q;
        cell_wdata_s = CLEAR_VAL;
        clr_cnt_d    = clr_cnt_q + 8'd1;
        if (clr_cnt_q == 8'd255) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_CLEAR;
        end
      end
      S_IDLE: begin
`ifdef BOARD_STORE_UNDO_EN
        // Undo takes priority over a simultaneous placement request
        if (undo_valid && hist_valid_q) begin
          cell_we_s    = 1'b1;
          cell_waddr_s = hist_addr_q;
          cell_wdata_s = CLEAR_VAL;
          turn_d       = hist_stone_q;
          move_count_d = move_count_q - 9'd1;
          hist_valid_d = 1'b0;
        end else
`endif
        if (place_valid && ready_s) begin
          if (target_cell_s == CLEAR_VAL) begin
            cell_we_s    = 1'b1;
            cell_waddr_s = pointer;
            cell_wdata_s = turn_q;
            place_ok_d   = 1'b1;
            chess_d      = turn_q;
            turn_d       = (turn_q == 2'd1) ? 2'd2 : 2'd1;
            move_count_d = move_count_q + 9'd1;
            active_d     = 1'b1;
            state_d      = S_CHECK;
`ifdef BOARD_STORE_UNDO_EN
            hist_valid_d = 1'b1;
            hist_addr_d  = pointer;
            hist_stone_d = turn_q;
`endif
          end else begin
            place_err_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CHECK: begin
        active_d = 1'b1;
        if (check_done) begin
          active_d = 1'b0;
          state_d  = S_IDLE;
        end else begin
          state_d  = S_CHECK;
        end
      end
      default: begin
        state_d   = S_CLEAR;
        clr_cnt_d = 8'd0;
        active_d  = 1'b0;
      end
    endcase
  end

  // Sequencer and status registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_CLEAR;
      clr_cnt_q    <= 8'd0;
      place_ok_q   <= 1'b0;
      place_err_q  <= 1'b0;
      chess_q      <= 2'd0;
      active_q     <= 1'b0;
      turn_q       <= 2'd1;
      move_count_q <= 9'd0;
`ifdef BOARD_STORE_UNDO_EN
      hist_valid_q <= 1'b0;
      hist_addr_q  <= 8'd0;
      hist_stone_q <= 2'd0;
`endif
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      place_ok_q   <= place_ok_d;
      place_err_q  <= place_err_d;
      chess_q      <= chess_d;
      active_q     <= active_d;
      turn_q       <= turn_d;
      move_count_q <= move_count_d;
`ifdef BOARD_STORE_UNDO_EN
      hist_valid_q <= hist_valid_d;
      hist_addr_q  <= hist_addr_d;
      hist_stone_q <= hist_stone_d;
`endif
    end
  end

  // Cell storage is wiped by the CLEAR sweep rather than by reset
  always_ff @(posedge clk) begin
    if (reset && cell_we_s) begin
      cells_q[cell_waddr_s] <= cell_wdata_s;
    end
  end

  assign place_ready = ready_s;
  assign place_ok    = place_ok_q;
  assign place_err   = place_err_q;
  assign chess       = chess_q;
  assign active      = active_q;
  assign turn        = turn_q;
  assign move_count  = move_count_q;
  assign board_full  = full_s;
  assign currstate   = (state_q == S_CLEAR) ? CLEAR_VAL : cells_q[address];

endmodule

// File: tb/tb_board_store.sv
// Directed self-checking bench for board_store: clear sweep, placement,
// occupied-cell rejection, requests during CHECK, full board and reset mid-CHECK.
module tb_board_store;

  logic       clk;
  logic       reset;
  logic [7:0] pointer;
  logic       place_valid;
  logic       place_ready;
  logic       place_ok;
  logic       place_err;
  logic [1:0] chess;
  logic       active;
  logic       check_done;
  logic [7:0] address;
  logic [1:0] currstate;
  logic [1:0] turn;
  logic [8:0] move_count;
  logic       board_full;
`ifdef BOARD_STORE_UNDO_EN
  logic       undo_valid;
`endif

  int total;
  int bad;

  board_store #(.CLEAR_VAL(2'd0)) dut (
    .clk         (clk),
    .reset       (reset),
    .pointer     (pointer),
    .place_valid (place_valid),
`ifdef BOARD_STORE_UNDO_EN
    .undo_valid  (undo_valid),
`endif
    .place_ready (place_ready),
    .place_ok    (place_ok),
    .place_err   (place_err),
    .chess       (chess),
    .active      (active),
    .check_done  (check_done),
    .address     (address),
    .currstate   (currstate),
    .turn        (turn),
    .move_count  (move_count),
    .board_full  (board_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    reset       = 1'b0;
    pointer     = 8'd0;
    place_valid = 1'b0;
    check_done  = 1'b0;
    address     = 8'h37;
`ifdef BOARD_STORE_UNDO_EN
    undo_valid  = 1'b0;
`endif

    // Reset held low for two edges
    step();
    step();
    chk("rst_ready", 9'(place_ready), 9'd0);
    chk("rst_ok",    9'(place_ok),    9'd0);
    chk("rst_err",   9'(place_err),   9'd0);
    chk("rst_chess", 9'(chess),       9'd0);
    chk("rst_active",9'(active),      9'd0);
    chk("rst_turn",  9'(turn),        9'd1);
    chk("rst_count", move_count,      9'd0);
    chk("rst_full",  9'(board_full),  9'd0);
    chk("rst_curr",  9'(currstate),   9'd0);
    reset = 1'b1;

    // Clear sweep: 256 edges, ready first seen after the 256th
    chk("clr_ready_c1", 9'(place_ready), 9'd0);
    for (int k = 1; k < 256; k++) begin
      step();
      chk("clr_ready", 9'(place_ready), 9'd0);
    end
    step();
    chk("clr_ready_done", 9'(place_ready), 9'd1);
    for (int a = 0; a < 256; a++) begin
      address = 8'(a);
      #1;
      chk("clr_cell", 9'(currstate), 9'd0);
    end

    // First placement at 0x37
    pointer     = 8'h37;
    place_valid = 1'b1;
    step();
    place_valid = 1'b0;
    pointer     = 8'h00;
    chk("p1_ok",     9'(place_ok),    9'd1);
    chk("p1_err",    9'(place_err),   9'd0);
    chk("p1_chess",  9'(chess),       9'd1);
    chk("p1_turn",   9'(turn),        9'd2);
    chk("p1_count",  move_count,      9'd1);
    chk("p1_active", 9'(active),      9'd1);
    chk("p1_ready",  9'(place_ready), 9'd0);
    address = 8'h37;
    #1;
    chk("p1_curr",   9'(currstate),   9'd1);
    check_done = 1'b1;
    step();
    check_done = 1'b0;
    chk("p1_active_off", 9'(active),      9'd0);
    chk("p1_ok_pulse",   9'(place_ok),    9'd0);
    chk("p1_ready_back", 9'(place_ready), 9'd1);
    chk("p1_chess_hold", 9'(chess),       9'd1);

    // Occupied target is rejected
    pointer     = 8'h37;
    place_valid = 1'b1;
    step();
    place_valid = 1'b0;
    chk("occ_err",    9'(place_err), 9'd1);
    chk("occ_ok",     9'(place_ok),  9'd0);
    chk("occ_turn",   9'(turn),      9'd2);
    chk("occ_count",  move_count,    9'd1);
    chk("occ_active", 9'(active),    9'd0);
    step();
    chk("occ_err_pulse", 9'(place_err), 9'd0);

    // place_valid held through CHECK; pointer changes after accept
    pointer     = 8'h10;
    place_valid = 1'b1;
    step();
    pointer = 8'h11;
    chk("ign_ok1",    9'(place_ok), 9'd1);
    chk("ign_chess1", 9'(chess),    9'd2);
    chk("ign_turn1",  9'(turn),     9'd1);
    chk("ign_count1", move_count,   9'd2);
    step();
    chk("ign_ok_chk_a",  9'(place_ok), 9'd0);
    chk("ign_cnt_chk_a", move_count,   9'd2);
    step();
    chk("ign_ok_chk_b",  9'(place_ok),  9'd0);
    chk("ign_err_chk_b", 9'(place_err), 9'd0);
    chk("ign_active",    9'(active),    9'd1);
    check_done = 1'b1;
    step();
    check_done = 1'b0;
    chk("ign_idle_active", 9'(active), 9'd0);
    chk("ign_idle_count",  move_count, 9'd2);
    step();
    place_valid = 1'b0;
    chk("ign_ok2",    9'(place_ok), 9'd1);
    chk("ign_chess2", 9'(chess),    9'd1);
    chk("ign_count2", move_count,   9'd3);
    step();
    chk("ign_count3", move_count,   9'd3);
    address = 8'h10;
    #1;
    chk("ign_cell10", 9'(currstate), 9'd2);
    address = 8'h11;
    #1;
    chk("ign_cell11", 9'(currstate), 9'd1);
    check_done = 1'b1;
    step();
    check_done = 1'b0;

    // Fill the rest of the board; check_done meets active on its rising cycle
    for (int a = 0; a < 256; a++) begin
      if (a != 8'h37 && a != 8'h10 && a != 8'h11) begin
        pointer     = 8'(a);
        place_valid = 1'b1;
        step();
        place_valid = 1'b0;
        chk("fill_ok", 9'(place_ok), 9'd1);
        check_done = 1'b1;
        step();
        check_done = 1'b0;
        chk("fill_active_off", 9'(active), 9'd0);
      end
    end
    chk("full_count", move_count,       9'd256);
    chk("full_flag",  9'(board_full),   9'd1);
    chk("full_ready", 9'(place_ready),  9'd0);
    chk("full_turn",  9'(turn),         9'd1);
    chk("full_chess", 9'(chess),        9'd2);
    address = 8'hFF;
    #1;
    chk("full_cellff", 9'(currstate), 9'd2);
    pointer     = 8'h37;
    place_valid = 1'b1;
    step();
    step();
    place_valid = 1'b0;
    chk("full_no_ok",  9'(place_ok),  9'd0);
    chk("full_no_err", 9'(place_err), 9'd0);
    chk("full_count2", move_count,    9'd256);

    // Reset, clear, place, then reset mid-CHECK
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("rst2_count", move_count,     9'd0);
    chk("rst2_full",  9'(board_full), 9'd0);
    for (int k = 0; k < 256; k++) step();
    chk("rst2_ready", 9'(place_ready), 9'd1);
    pointer     = 8'h37;
    place_valid = 1'b1;
    step();
    place_valid = 1'b0;
    chk("mid_active", 9'(active), 9'd1);
    chk("mid_count",  move_count, 9'd1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("mid_rst_active", 9'(active),      9'd0);
    chk("mid_rst_count",  move_count,      9'd0);
    chk("mid_rst_turn",   9'(turn),        9'd1);
    chk("mid_rst_chess",  9'(chess),       9'd0);
    chk("mid_rst_ready",  9'(place_ready), 9'd0);
    address = 8'h37;
    step();
    chk("mid_clr_forced", 9'(currstate),   9'd0);
    chk("mid_clr_ready",  9'(place_ready), 9'd0);
    for (int k = 1; k < 256; k++) step();
    chk("mid_clr_done", 9'(place_ready), 9'd1);
    #1;
    chk("mid_cell37", 9'(currstate), 9'd0);

    // New game starts with black at 0x00
    pointer     = 8'h00;
    place_valid = 1'b1;
    step();
    place_valid = 1'b0;
    chk("ng_ok",    9'(place_ok), 9'd1);
    chk("ng_chess", 9'(chess),    9'd1);
    check_done = 1'b1;
    step();
    check_done = 1'b0;

`ifdef BOARD_STORE_UNDO_EN
    undo_valid = 1'b1;
    step();
    undo_valid = 1'b0;
    address = 8'h00;
    #1;
    chk("undo_cell",  9'(currstate), 9'd0);
    chk("undo_turn",  9'(turn),      9'd1);
    chk("undo_count", move_count,    9'd0);
    chk("undo_ok",    9'(place_ok),  9'd0);
    chk("undo_act",   9'(active),    9'd0);
    undo_valid = 1'b1;
    step();
    undo_valid = 1'b0;
    chk("undo2_turn",  9'(turn),   9'd1);
    chk("undo2_count", move_count, 9'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
